// File: rtl/mult_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb_if
// Purpose  : Bundles the signals between the requesters, the multiplier
//            arbiter and the shared sequential multiplier.
//            slave  : arbiter view. It samples requests and the multiplier
//                     result, and drives grants, results and multiplier
//                     controls.
//            master : environment view (requesters plus multiplier).
// Ports    : req/req_mlier/req_mcand (request side)
//            gnt/done/prod/busy      (result side)
//            mul_start/mul_mlier/mul_mcand/mul_prodt/mul_valid (multiplier)
//            err (only when MULT_ARB_TIMEOUT_EN is defined)
// Revision : 1.0  initial release
// ============================================================================
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_mlier;
  logic [NREQ*W-1:0] req_mcand;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    prod;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_mlier;
  logic [W-1:0]      mul_mcand;
  logic [2*W-1:0]    mul_prodt;
  logic              mul_valid;
`ifdef MULT_ARB_TIMEOUT_EN
  logic              err;

  modport slave (
    input  req, req_mlier, req_mcand, mul_prodt, mul_valid,
    output gnt, done, prod, busy, mul_start, mul_mlier, mul_mcand, err
  );
  modport master (
    output req, req_mlier, req_mcand, mul_prodt, mul_valid,
    input  gnt, done, prod, busy, mul_start, mul_mlier, mul_mcand, err
  );
`else
  modport slave (
    input  req, req_mlier, req_mcand, mul_prodt, mul_valid,
    output gnt, done, prod, busy, mul_start, mul_mlier, mul_mcand
  );
  modport master (
    output req, req_mlier, req_mcand, mul_prodt, mul_valid,
    input  gnt, done, prod, busy, mul_start, mul_mlier, mul_mcand
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Purpose  : Round-robin arbiter/sequencer that shares one sequential
//            W x W multiplier among NREQ requesters. It latches the winner's
//            operands, holds mul_start until the multiplier reports valid,
//            captures the 2W-bit product and pulses done to the owner. It
//            then keeps mul_start low for at least two cycles.
// Ports    : clock  rising-edge clock
//            reset  asynchronous active-high reset
//            bus    mult_share_arb_if.slave (requests, grants, multiplier link)
// Options  : MULT_ARB_TIMEOUT_EN  adds err and aborts a RUN that lasts
//                                 TIMEOUT cycles without mul_valid
// Revision : 1.0  initial release
// ============================================================================
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 40
) (
  input  wire logic       clock,
  input  wire logic       reset,
  mult_share_arb_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state;
  logic [PW-1:0]     r_ptr, w_ptr;
  logic [PW-1:0]     r_owner, w_owner;
  logic [NREQ-1:0]   r_gnt, w_gnt;
  logic [NREQ-1:0]   r_done, w_done;
  logic [2*W-1:0]    r_prod, w_prod;
  logic              r_start, w_start;
  logic [W-1:0]      r_mlier, w_mlier;
  logic [W-1:0]      r_mcand, w_mcand;

  logic              w_found;
  logic [PW-1:0]     w_pick;
  logic [PW:0]       w_idx;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic              r_err, w_err;
  logic [CW-1:0]     r_cnt, w_cnt;
`endif

  // Round-robin scan: first set request at or above r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      if (!w_found && bus.req[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PW-1:0];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_gnt   = r_gnt;
    w_done  = '0;
    w_prod  = r_prod;
    w_start = r_start;
    w_mlier = r_mlier;
    w_mcand = r_mcand;
`ifdef MULT_ARB_TIMEOUT_EN
    w_err   = 1'b0;
    w_cnt   = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state = ST_RUN;
          w_owner = w_pick;
          w_gnt   = NREQ'(1) << w_pick;
          // Operands are frozen here; the requester may change them afterwards.
          w_mlier = bus.req_mlier[w_pick*W +: W];
          w_mcand = bus.req_mcand[w_pick*W +: W];
          w_start = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
          w_cnt   = '0;
`endif
        end
      end
      ST_RUN: begin
        if (bus.mul_valid) begin
          w_prod  = bus.mul_prodt;
          w_done  = r_gnt;
          w_start = 1'b0;
          w_state = ST_DONE;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_prod  = '0;
          w_done  = r_gnt;
          w_err   = 1'b1;
          w_start = 1'b0;
          w_state = ST_DONE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        // The DONE cycle plus the following IDLE cycle give the multiplier a
        // start-low gap of at least two cycles.
        w_ptr   = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        w_gnt   = '0;
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
        w_gnt   = '0;
        w_start = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_prod  <= '0;
      r_start <= 1'b0;
      r_mlier <= '0;
      r_mcand <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_err   <= 1'b0;
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_prod  <= w_prod;
      r_start <= w_start;
      r_mlier <= w_mlier;
      r_mcand <= w_mcand;
`ifdef MULT_ARB_TIMEOUT_EN
      r_err   <= w_err;
      r_cnt   <= w_cnt;
`endif
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.prod      = r_prod;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.mul_start = r_start;
  assign bus.mul_mlier = r_mlier;
  assign bus.mul_mcand = r_mcand;
`ifdef MULT_ARB_TIMEOUT_EN
  assign bus.err       = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arb
// Purpose  : Directed self-checking bench for mult_share_arb. A behavioural
//            sequential multiplier asserts valid LAT cycles after start and
//            holds it until start drops. When stub is set, it never asserts
//            valid.
// Options  : MULT_ARB_TIMEOUT_EN  also exercises the RUN timeout abort
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 5;

  logic clock = 1'b0;
  logic reset;
  logic stub;
  int   mcnt;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  mult_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(40)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural multiplier
  always @(posedge clock or posedge reset) begin
    if (reset || !bus.mul_start) begin
      mcnt          <= 0;
      bus.mul_valid <= 1'b0;
      bus.mul_prodt <= '0;
    end else if (!stub) begin
      if (mcnt == LAT) begin
        bus.mul_valid <= 1'b1;
        bus.mul_prodt <= 64'(bus.mul_mlier) * 64'(bus.mul_mcand);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req[i]                = 1'b1;
    bus.req_mlier[i*W +: W]   = a;
    bus.req_mcand[i*W +: W]   = b;
  endtask

  // Called at a negedge before the granting edge; grant must appear one edge later.
  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    while (bus.gnt == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, " gnt"}, 64'(bus.gnt), 64'(exp));
    check_val({tag, " latency"}, 64'(n), 64'd1);
    check_val({tag, " start"}, 64'(bus.mul_start), 64'd1);
    check_val({tag, " busy"}, 64'(bus.busy), 64'd1);
  endtask

  // Waits for done, checks the DONE cycle, then steps into IDLE and checks it.
  task automatic wait_done(input string tag, input int owner, input logic [63:0] exp);
    int n = 0;
    while (bus.done == '0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, " done"}, 64'(bus.done), 64'(4'b1 << owner));
    check_val({tag, " prod"}, bus.prod, exp);
    check_val({tag, " gnt held"}, 64'(bus.gnt), 64'(4'b1 << owner));
    check_val({tag, " start low in DONE"}, 64'(bus.mul_start), 64'd0);
    check_val({tag, " busy in DONE"}, 64'(bus.busy), 64'd1);
    @(negedge clock);
    check_val({tag, " done pulse"}, 64'(bus.done), 64'd0);
    check_val({tag, " gnt clear"}, 64'(bus.gnt), 64'd0);
    check_val({tag, " start low in IDLE"}, 64'(bus.mul_start), 64'd0);
    check_val({tag, " idle"}, 64'(bus.busy), 64'd0);
    check_val({tag, " prod hold"}, bus.prod, exp);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_val({tag, " rst gnt"}, 64'(bus.gnt), 64'd0);
    check_val({tag, " rst done"}, 64'(bus.done), 64'd0);
    check_val({tag, " rst busy"}, 64'(bus.busy), 64'd0);
    check_val({tag, " rst start"}, 64'(bus.mul_start), 64'd0);
    check_val({tag, " rst prod"}, bus.prod, 64'd0);
    check_val({tag, " rst mlier"}, 64'(bus.mul_mlier), 64'd0);
    check_val({tag, " rst mcand"}, 64'(bus.mul_mcand), 64'd0);
`ifdef MULT_ARB_TIMEOUT_EN
    check_val({tag, " rst err"}, 64'(bus.err), 64'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    stub          = 1'b0;
    bus.req       = '0;
    bus.req_mlier = '0;
    bus.req_mcand = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    apply_reset("t0");

    // 1: single request on 0; operands scrambled after grant must not matter
    set_req(0, 32'h8, 32'h0001_2345);
    wait_grant("t1", 4'b0001);
    bus.req       = '0;
    bus.req_mlier = '1;
    bus.req_mcand = '1;
    check_val("t1 mlier", 64'(bus.mul_mlier), 64'h8);
    @(negedge clock);
    check_val("t1 mcand held", 64'(bus.mul_mcand), 64'h0001_2345);
    wait_done("t1", 0, 64'h91A28);

    // 2: request on 1
    set_req(1, 32'h2, 32'h000f_ffff);
    wait_grant("t2", 4'b0010);
    bus.req = '0;
    wait_done("t2", 1, 64'h1f_fffe);
    @(negedge clock);
    check_val("t2 start gap", 64'(bus.mul_start), 64'd0);

    // 3: simultaneous 0 and 2 from pointer 0
    apply_reset("t3");
    set_req(0, 32'h4, 32'h000f_ffff);
    set_req(2, 32'h8, 32'h000f_ffff);
    wait_grant("t3a", 4'b0001);
    wait_done("t3a", 0, 64'h3f_fffc);
    bus.req[0] = 1'b0;
    wait_grant("t3b", 4'b0100);
    bus.req = '0;
    wait_done("t3b", 2, 64'h7f_fff8);

    // 4: all four held, round-robin order 0,1,2,3,0
    apply_reset("t4");
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, 32'h0001_2345);
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("t4[%0d]", k), 4'b1 << (k % 4));
      wait_done($sformatf("t4[%0d]", k), k % 4, 64'h0);
    end
    bus.req = '0;

    // 5: reset in the middle of RUN
    set_req(1, 32'h3, 32'h5);
    wait_grant("t5", 4'b0010);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_val("t5 start drop", 64'(bus.mul_start), 64'd0);
    check_val("t5 gnt drop", 64'(bus.gnt), 64'd0);
    check_val("t5 busy drop", 64'(bus.busy), 64'd0);
    @(negedge clock);
    reset   = 1'b0;
    bus.req = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_val("t5 no done", 64'(bus.done), 64'd0);
    end
    set_req(0, 32'h6, 32'h7);
    set_req(1, 32'h3, 32'h5);
    wait_grant("t5b", 4'b0001);
    bus.req = '0;
    wait_done("t5b", 0, 64'd42);

`ifdef MULT_ARB_TIMEOUT_EN
    // 6: multiplier never answers
    begin
      int n = 0;
      stub = 1'b1;
      set_req(0, 32'h6, 32'h7);
      wait_grant("t6", 4'b0001);
      bus.req = '0;
      while (bus.done == '0 && n < 100) begin
        @(negedge clock);
        n++;
      end
      check_val("t6 run cycles", 64'(n), 64'd40);
      check_val("t6 done", 64'(bus.done), 64'h1);
      check_val("t6 err", 64'(bus.err), 64'd1);
      check_val("t6 prod", bus.prod, 64'd0);
      check_val("t6 start", 64'(bus.mul_start), 64'd0);
      @(negedge clock);
      check_val("t6 err pulse", 64'(bus.err), 64'd0);
      stub = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
